vx_gbar_ctrl: RTL and testbench

Global barrier controller on the slave side of the cluster-level barrier interface. Accepts barrier-arrival requests from up to NUM_CORES cores and arbitrates them round-robin, one per cycle. Counts arrivals per barrier ID and broadcasts a one-cycle release response to all cores when the last participant arrives. Sits in the cluster, between the per-core barrier request ports and the shared release broadcast.

---
 rtl/vx_gbar_pkg.sv | 17 +
 rtl/vx_gbar_ctrl_if.sv | 23 ++
 rtl/vx_gbar_rr_arb.sv | 40 ++++
 rtl/vx_gbar_ctrl.sv | 94 +++++++++
 tb/tb_vx_gbar_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/vx_gbar_pkg.sv
// Shared types and widths for the global barrier controller.
package vx_gbar_pkg;
  localparam int NUM_CORES    = 4;
  localparam int NUM_BARRIERS = 8;
  localparam int NC_BITS      = $clog2(NUM_CORES);
  localparam int NB_BITS      = $clog2(NUM_BARRIERS);
  // core index / count width, never zero even for a single core
  localparam int NCW          = (NC_BITS > 0) ? NC_BITS : 1;

  typedef logic [NCW-1:0] gbar_cnt_t;

  typedef struct packed {
    logic [NB_BITS-1:0] id;
    gbar_cnt_t          size_m1;
    gbar_cnt_t          core_id;
  } gbar_req_t;
endpackage

// File: rtl/vx_gbar_ctrl_if.sv
// Per-core barrier request ports plus the shared release broadcast.
interface vx_gbar_ctrl_if;
  import vx_gbar_pkg::*;

  logic [NUM_CORES-1:0]              req_valid;
  logic [NUM_CORES-1:0][NB_BITS-1:0] req_id;
  logic [NUM_CORES-1:0][NCW-1:0]     req_size_m1;
  logic [NUM_CORES-1:0][NCW-1:0]     req_core_id;
  logic [NUM_CORES-1:0]              req_ready;
  logic                              rsp_valid;
  logic [NB_BITS-1:0]                rsp_id;
  logic                              dup_err;

  modport master (
    output req_valid, req_id, req_size_m1, req_core_id,
    input  req_ready, rsp_valid, rsp_id, dup_err
  );

  modport slave (
    input  req_valid, req_id, req_size_m1, req_core_id,
    output req_ready, rsp_valid, rsp_id, dup_err
  );
endinterface

// File: rtl/vx_gbar_rr_arb.sv
// Round-robin arbiter: one-hot grant to the first valid at or after the
// pointer; pointer moves past the winner, holds when idle.
module vx_gbar_rr_arb #(
  parameter int NUM_REQS = 4,
  parameter int IDXW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQS-1:0] valid,
  output logic [NUM_REQS-1:0] grant,
  output logic [IDXW-1:0]     grant_idx,
  output logic                grant_any
);
  logic [IDXW-1:0] rr_ptr;

  // priority scan starting at rr_ptr, wrapping
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQS;
      if (!grant_any && valid[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDXW'(idx);
        grant_any  = 1'b1;
      end
    end
  end

  // advance pointer to the slot after the winner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      rr_ptr <= '0;
    else if (grant_any)
      rr_ptr <= (grant_idx == IDXW'(NUM_REQS-1)) ? '0 : grant_idx + 1'b1;
  end
endmodule

// File: rtl/vx_gbar_ctrl.sv
// Global barrier controller: arbitrates core arrivals one per cycle, counts
// them per barrier ID and pulses a release when the last one arrives.
// Optional feature: VX_GBAR_DUP_CHECK_EN adds per-barrier arrival masks that
// drop repeated arrivals from the same core and raise a sticky dup_err.
module vx_gbar_ctrl
  import vx_gbar_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  vx_gbar_ctrl_if.slave bus
);
  logic [NUM_CORES-1:0] grant;
  logic [NCW-1:0]       gidx;
  logic                 acc;
  gbar_req_t            sel;
  gbar_cnt_t            cnt [NUM_BARRIERS];
  logic                 rsp_valid_q;
  logic [NB_BITS-1:0]   rsp_id_q;
  logic                 hit;

  vx_gbar_rr_arb #(.NUM_REQS(NUM_CORES), .IDXW(NCW)) arb (
    .clk       (clk),
    .reset     (reset),
    .valid     (bus.req_valid),
    .grant     (grant),
    .grant_idx (gidx),
    .grant_any (acc)
  );

  assign bus.req_ready = grant;

  // payload of the granted core
  always_comb begin
    sel         = '0;
    sel.id      = bus.req_id[gidx];
    sel.size_m1 = bus.req_size_m1[gidx];
    sel.core_id = bus.req_core_id[gidx];
  end

  // the releasing arrival's size is the one that counts
  assign hit = (cnt[sel.id] == sel.size_m1);

`ifdef VX_GBAR_DUP_CHECK_EN
  logic [NUM_CORES-1:0] mask [NUM_BARRIERS];
  logic                 dup_err_q;
  logic                 dup;

  assign dup         = mask[sel.id][sel.core_id];
  assign bus.dup_err = dup_err_q;
`else
  logic unused_core;
  assign unused_core = ^sel.core_id;
  assign bus.dup_err = 1'b0;
`endif

  // count arrivals, release and recycle the barrier on the last one
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) cnt[b] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
`ifdef VX_GBAR_DUP_CHECK_EN
      for (int b = 0; b < NUM_BARRIERS; b++) mask[b] <= '0;
      dup_err_q <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
`ifdef VX_GBAR_DUP_CHECK_EN
      if (acc && dup) begin
        dup_err_q <= 1'b1;
      end else if (acc) begin
`else
      if (acc) begin
`endif
        if (hit) begin
          cnt[sel.id] <= '0;
          rsp_valid_q <= 1'b1;
          rsp_id_q    <= sel.id;
`ifdef VX_GBAR_DUP_CHECK_EN
          mask[sel.id] <= '0;
`endif
        end else begin
          cnt[sel.id] <= cnt[sel.id] + 1'b1;
`ifdef VX_GBAR_DUP_CHECK_EN
          mask[sel.id][sel.core_id] <= 1'b1;
`endif
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_vx_gbar_ctrl.sv
// Bench for vx_gbar_ctrl: per-core request queues drive the bus, a
// behavioural model is checked every cycle, directed scenarios pin results.
module tb_vx_gbar_ctrl;
  import vx_gbar_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_gbar_ctrl_if bus();
  vx_gbar_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  int q_id [NUM_CORES][$];
  int q_sz [NUM_CORES][$];
  logic [NUM_CORES-1:0] acc_m = '0;

  // model state
  int m_cnt [NUM_BARRIERS];
  bit [NUM_CORES-1:0] m_mask [NUM_BARRIERS];
  int m_ptr = 0;
  bit m_rv = 0;
  int m_rid = 0;
  bit m_dup = 0;

  // logs for the directed checks
  int glog[$];
  int gcyc[$];
  int rcyc[$];
  int rid[$];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // every-cycle compare against the model, then step the model
  always @(negedge clk) begin
    int eidx, b, s, c;
    logic [NUM_CORES-1:0] eg;
    cyc++;
    if (!reset) begin
      chk("reset_ready", bus.req_ready, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_id", bus.rsp_id, 0);
      chk("reset_dup_err", bus.dup_err, 0);
      for (int i = 0; i < NUM_BARRIERS; i++) begin m_cnt[i] = 0; m_mask[i] = '0; end
      m_ptr = 0; m_rv = 0; m_rid = 0; m_dup = 0;
      acc_m = '0;
    end else begin
      eidx = -1;
      eg = '0;
      for (int k = 0; k < NUM_CORES; k++) begin
        int i;
        i = (m_ptr + k) % NUM_CORES;
        if (eidx < 0 && bus.req_valid[i]) eidx = i;
      end
      if (eidx >= 0) eg[eidx] = 1'b1;
      chk("req_ready", bus.req_ready, eg);
      chk("rsp_valid", bus.rsp_valid, m_rv);
      if (m_rv) chk("rsp_id", bus.rsp_id, m_rid);
      chk("dup_err", bus.dup_err, m_dup);
      if (bus.rsp_valid) begin rcyc.push_back(cyc); rid.push_back(int'(bus.rsp_id)); end
      acc_m = bus.req_valid & bus.req_ready;
      m_rv = 0;
      if (eidx >= 0) begin
        glog.push_back(int'(bus.req_ready));
        gcyc.push_back(cyc);
        m_ptr = (eidx + 1) % NUM_CORES;
        b = int'(bus.req_id[eidx]);
        s = int'(bus.req_size_m1[eidx]);
        c = int'(bus.req_core_id[eidx]);
`ifdef VX_GBAR_DUP_CHECK_EN
        if (m_mask[b][c]) m_dup = 1;
        else
`endif
        if (m_cnt[b] == s) begin
          m_cnt[b] = 0; m_rv = 1; m_rid = b; m_mask[b] = '0;
        end else begin
          m_cnt[b] = m_cnt[b] + 1; m_mask[b][c] = 1'b1;
        end
      end
    end
  end

  task automatic push(int core, int id, int sz);
    q_id[core].push_back(id);
    q_sz[core].push_back(sz);
  endtask

  task automatic clear_logs();
    glog.delete(); gcyc.delete(); rcyc.delete(); rid.delete();
  endtask

  task automatic drain();
    bit busy;
    busy = 1;
    for (int c = 0; c < 200 && busy; c++) begin
      @(negedge clk);
      busy = 0;
      for (int i = 0; i < NUM_CORES; i++) if (q_id[i].size() > 0) busy = 1;
    end
    if (busy) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #2 reset = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid   = '0;
    bus.req_id      = '0;
    bus.req_size_m1 = '0;
    bus.req_core_id = '0;
    // drive queues onto the bus just after each rising edge
    fork
      forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CORES; i++)
          if (acc_m[i] && q_id[i].size() > 0) begin
            void'(q_id[i].pop_front());
            void'(q_sz[i].pop_front());
          end
        for (int i = 0; i < NUM_CORES; i++) begin
          if (q_id[i].size() > 0) begin
            bus.req_valid[i]   = 1'b1;
            bus.req_id[i]      = NB_BITS'(q_id[i][0]);
            bus.req_size_m1[i] = NCW'(q_sz[i][0]);
            bus.req_core_id[i] = NCW'(i);
          end else begin
            bus.req_valid[i] = 1'b0;
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);

    // full barrier: all four on id 1, size 4
    clear_logs();
    for (int i = 0; i < 4; i++) push(i, 1, 3);
    drain();
    chk("full_ngrant", glog.size(), 4);
    for (int k = 0; k < 4 && k < glog.size(); k++) chk("full_order", glog[k], 1 << k);
    chk("full_nrsp", rid.size(), 1);
    if (rid.size() == 1 && gcyc.size() == 4) begin
      chk("full_rsp_id", rid[0], 1);
      chk("full_latency", rcyc[0], gcyc[3] + 1);
    end

    // single core release; pointer is back at 0
    clear_logs();
    push(2, 3, 0);
    drain();
    chk("single_ngrant", glog.size(), 1);
    if (glog.size() == 1) chk("single_ready", glog[0], 4'b0100);
    chk("single_nrsp", rid.size(), 1);
    if (rid.size() == 1 && gcyc.size() == 1) begin
      chk("single_rsp_id", rid[0], 3);
      chk("single_latency", rcyc[0], gcyc[0] + 1);
    end

    // fairness: four cores, each on its own id, four requests each
    do_reset();
    clear_logs();
    for (int i = 0; i < 4; i++) for (int r = 0; r < 4; r++) push(i, 4 + i, 3);
    drain();
    chk("fair_ngrant", glog.size(), 16);
    for (int k = 0; k < 16 && k < glog.size(); k++) chk("fair_order", glog[k], 1 << (k % 4));
    if (gcyc.size() == 16) chk("fair_backtoback", gcyc[15] - gcyc[0], 15);
`ifdef VX_GBAR_DUP_CHECK_EN
    chk("fair_nrsp", rid.size(), 0);
`else
    chk("fair_nrsp", rid.size(), 4);
`endif

    // interleaved ids 0 and 5, pairs
    do_reset();
    clear_logs();
    push(0, 0, 1); push(1, 0, 1); push(2, 5, 1); push(3, 5, 1);
    drain();
    chk("inter_nrsp", rid.size(), 2);
    if (rid.size() == 2 && gcyc.size() == 4) begin
      chk("inter_id0", rid[0], 0);
      chk("inter_id1", rid[1], 5);
      chk("inter_lat0", rcyc[0], gcyc[1] + 1);
      chk("inter_lat1", rcyc[1], gcyc[3] + 1);
    end

    // reset mid-barrier discards partial arrivals
    clear_logs();
    push(0, 2, 3); push(1, 2, 3);
    drain();
    do_reset();
    clear_logs();
    push(0, 2, 3); push(1, 2, 3); push(2, 2, 3);
    drain();
    chk("rst_no_early_rsp", rid.size(), 0);
    push(3, 2, 3);
    drain();
    chk("rst_nrsp", rid.size(), 1);
    if (rid.size() == 1) chk("rst_rsp_id", rid[0], 2);

`ifdef VX_GBAR_DUP_CHECK_EN
    // duplicate arrival from core 1 is swallowed
    do_reset();
    clear_logs();
    push(1, 0, 1); push(1, 0, 1);
    drain();
    chk("dup_nrsp", rid.size(), 0);
    chk("dup_flag", bus.dup_err, 1);
    push(0, 0, 1);
    drain();
    chk("dup_release", rid.size(), 1);
    if (rid.size() == 1) chk("dup_rsp_id", rid[0], 0);
    chk("dup_sticky", bus.dup_err, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
